cpu_bus_cycle: RTL and testbench

//  Sits directly downstream of the CPU microcode sequencer. It owns the free-running
//  T-cycle counter that the sequencer keys off, and turns its mem_enable/mem_write

---
 rtl/cpu_bus_cycle_if.sv | 31 +++
 rtl/cpu_bus_cycle.sv | 128 ++++++++++++
 tb/tb_cpu_bus_cycle.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_cycle_if.sv
// External memory bus between the bus-cycle controller and the memory/peripheral side.
// The controller is the master; the addressed device is the slave.
interface cpu_bus_cycle_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output addr,
    output wdata,
    output rd,
    output wr,
    input  rdata,
    input  ready
  );

  modport slave (
    input  addr,
    input  wdata,
    input  rd,
    input  wr,
    output rdata,
    output ready
  );
endinterface

// File: rtl/cpu_bus_cycle.sv
// T-cycle counter and 4-T M-cycle bus sequencer behind the microcode sequencer.
// T3 stretches while the bus is not ready, up to WAIT_MAX stalls, then the access aborts.
//
//   state  | meaning
//   IDLE   | t_cycle free-running; a request is accepted on a t_cycle==0 edge
//   ACCESS | M-cycle in progress; T3 holds while ready is low, then completes or aborts
module cpu_bus_cycle #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [1:0]        t_cycle,
  input  logic              cpu_mem_enable,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdata_valid,
  output logic              bus_timeout,
  cpu_bus_cycle_if.master   bus
);

  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              is_write, is_write_nxt;
  logic [1:0]        t_cycle_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              rd_nxt, wr_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              valid_nxt, timeout_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      is_write        <= 1'b0;
      t_cycle         <= 2'd0;
      bus.addr        <= '0;
      bus.wdata       <= '0;
      bus.rd          <= 1'b0;
      bus.wr          <= 1'b0;
      cpu_rdata       <= '0;
      cpu_rdata_valid <= 1'b0;
      bus_timeout     <= 1'b0;
    end else begin
      state           <= state_nxt;
      wait_cnt        <= wait_cnt_nxt;
      is_write        <= is_write_nxt;
      t_cycle         <= t_cycle_nxt;
      bus.addr        <= addr_nxt;
      bus.wdata       <= wdata_nxt;
      bus.rd          <= rd_nxt;
      bus.wr          <= wr_nxt;
      cpu_rdata       <= rdata_nxt;
      cpu_rdata_valid <= valid_nxt;
      bus_timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    is_write_nxt = is_write;
    t_cycle_nxt  = t_cycle + 2'd1;
    addr_nxt     = bus.addr;
    wdata_nxt    = bus.wdata;
    rd_nxt       = bus.rd;
    wr_nxt       = bus.wr;
    rdata_nxt    = cpu_rdata;
    valid_nxt    = 1'b0;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if ((t_cycle == 2'd0) && cpu_mem_enable) begin
          addr_nxt     = cpu_addr;
          wdata_nxt    = cpu_wdata;
          is_write_nxt = cpu_mem_write;
          rd_nxt       = !cpu_mem_write;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        if ((t_cycle == 2'd1) && is_write) begin
          wr_nxt = 1'b1;
        end
        if (t_cycle == 2'd3) begin
          if (bus.ready) begin
            rd_nxt       = 1'b0;
            wr_nxt       = 1'b0;
            t_cycle_nxt  = 2'd0;
            wait_cnt_nxt = '0;
            state_nxt    = IDLE;
            if (!is_write) begin
              rdata_nxt = bus.rdata;
              valid_nxt = 1'b1;
            end
          end else if (wait_cnt < WAIT_LIM) begin
            // Holding T3 freezes the sequencer, which keys off t_cycle==0.
            wait_cnt_nxt = wait_cnt + 1'b1;
            t_cycle_nxt  = t_cycle;
          end else begin
            timeout_nxt  = 1'b1;
            rd_nxt       = 1'b0;
            wr_nxt       = 1'b0;
            t_cycle_nxt  = 2'd0;
            wait_cnt_nxt = '0;
            state_nxt    = IDLE;
            if (!is_write) begin
              rdata_nxt = {DATA_W{1'b1}};
              valid_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_cycle.sv
// Directed bench for cpu_bus_cycle: two instances, WAIT_MAX=7 and WAIT_MAX=2,
// share the CPU-side request inputs and reset; each has its own bus interface.
module tb_cpu_bus_cycle;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;

  logic [1:0]  t7, t2;
  logic [7:0]  rd7, rd2;
  logic        v7, v2, to7, to2;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_bus_cycle_if #(.ADDR_W(16), .DATA_W(8)) bif7 ();
  cpu_bus_cycle_if #(.ADDR_W(16), .DATA_W(8)) bif2 ();

  cpu_bus_cycle #(.ADDR_W(16), .DATA_W(8), .WAIT_MAX(7)) dut7 (
    .clk             (clk),
    .reset_n         (reset_n),
    .t_cycle         (t7),
    .cpu_mem_enable  (en),
    .cpu_mem_write   (wr),
    .cpu_addr        (addr),
    .cpu_wdata       (wdata),
    .cpu_rdata       (rd7),
    .cpu_rdata_valid (v7),
    .bus_timeout     (to7),
    .bus             (bif7)
  );

  cpu_bus_cycle #(.ADDR_W(16), .DATA_W(8), .WAIT_MAX(2)) dut2 (
    .clk             (clk),
    .reset_n         (reset_n),
    .t_cycle         (t2),
    .cpu_mem_enable  (en),
    .cpu_mem_write   (wr),
    .cpu_addr        (addr),
    .cpu_wdata       (wdata),
    .cpu_rdata       (rd2),
    .cpu_rdata_valid (v2),
    .bus_timeout     (to2),
    .bus             (bif2)
  );

  task automatic do_reset();
    en = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_t0();
    for (int i = 0; i < 8 && t7 != 2'd0; i++) @(negedge clk);
    n_assert++; if (t7 !== 2'd0) begin n_fail++; $display("FAIL wait_t0: t_cycle got %0d want 0 within 8 clk", t7); end
  endtask

  task automatic drive_req(input logic w, input logic [15:0] a, input logic [7:0] d);
    en = 1'b1;
    wr = w;
    addr = a;
    wdata = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_assert++; if (t7 !== 2'd0) begin n_fail++; $display("FAIL rst_tcycle: got %0d want 0", t7); end
    n_assert++; if (rd7 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", rd7); end
    n_assert++; if (v7 !== 1'b0 || to7 !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: valid %b timeout %b want 0 0", v7, to7); end
    n_assert++; if (bif7.addr !== 16'h0 || bif7.wdata !== 8'h0) begin n_fail++; $display("FAIL rst_bus: addr %h wdata %h want 0000 00", bif7.addr, bif7.wdata); end
    n_assert++; if (bif7.rd !== 1'b0 || bif7.wr !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: rd %b wr %b want 0 0", bif7.rd, bif7.wr); end
    n_assert++; if (t2 !== 2'd0 || to2 !== 1'b0 || bif2.rd !== 1'b0) begin n_fail++; $display("FAIL rst_dut2: t %0d timeout %b rd %b want 0 0 0", t2, to2, bif2.rd); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_assert++; if (t7 !== 2'(i)) begin n_fail++; $display("FAIL idle_tcycle[%0d]: got %0d want %0d", i, t7, i % 4); end
      n_assert++; if (bif7.rd !== 1'b0 || bif7.wr !== 1'b0) begin n_fail++; $display("FAIL idle_strobes[%0d]: rd %b wr %b want 0 0", i, bif7.rd, bif7.wr); end
      @(negedge clk);
    end
  endtask

  task automatic test_read();
    wait_t0();
    drive_req(1'b0, 16'hC000, 8'h00);
    bif7.ready = 1'b1;
    bif7.rdata = 8'h5A;
    @(negedge clk);
    en = 1'b0;
    addr = 16'h0000;
    for (int k = 1; k <= 3; k++) begin
      n_assert++; if (t7 !== 2'(k)) begin n_fail++; $display("FAIL rd_tcycle[%0d]: got %0d want %0d", k, t7, k); end
      n_assert++; if (bif7.rd !== 1'b1 || bif7.wr !== 1'b0) begin n_fail++; $display("FAIL rd_strobe[%0d]: rd %b wr %b want 1 0", k, bif7.rd, bif7.wr); end
      n_assert++; if (bif7.addr !== 16'hC000) begin n_fail++; $display("FAIL rd_addr[%0d]: got %h want c000", k, bif7.addr); end
      n_assert++; if (v7 !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid[%0d]: got %b want 0", k, v7); end
      @(negedge clk);
    end
    n_assert++; if (t7 !== 2'd0 || bif7.rd !== 1'b0) begin n_fail++; $display("FAIL rd_done: t %0d rd %b want 0 0", t7, bif7.rd); end
    n_assert++; if (v7 !== 1'b1 || rd7 !== 8'h5A) begin n_fail++; $display("FAIL rd_data: valid %b rdata %h want 1 5a", v7, rd7); end
    @(negedge clk);
    n_assert++; if (v7 !== 1'b0 || rd7 !== 8'h5A) begin n_fail++; $display("FAIL rd_hold: valid %b rdata %h want 0 5a", v7, rd7); end
  endtask

  task automatic test_write();
    wait_t0();
    drive_req(1'b1, 16'hFF40, 8'h91);
    @(negedge clk);
    en = 1'b0;
    wr = 1'b0;
    addr = 16'h0000;
    wdata = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      n_assert++; if (t7 !== 2'(k)) begin n_fail++; $display("FAIL wr_tcycle[%0d]: got %0d want %0d", k, t7, k); end
      n_assert++; if (bif7.wr !== (k >= 2) || bif7.rd !== 1'b0) begin n_fail++; $display("FAIL wr_strobe[%0d]: wr %b rd %b want %0d 0", k, bif7.wr, bif7.rd, (k >= 2)); end
      n_assert++; if (bif7.addr !== 16'hFF40 || bif7.wdata !== 8'h91) begin n_fail++; $display("FAIL wr_bus[%0d]: addr %h wdata %h want ff40 91", k, bif7.addr, bif7.wdata); end
      n_assert++; if (v7 !== 1'b0) begin n_fail++; $display("FAIL wr_valid[%0d]: got %b want 0", k, v7); end
      @(negedge clk);
    end
    n_assert++; if (t7 !== 2'd0 || bif7.wr !== 1'b0) begin n_fail++; $display("FAIL wr_done: t %0d wr %b want 0 0", t7, bif7.wr); end
    n_assert++; if (v7 !== 1'b0 || rd7 !== 8'h5A) begin n_fail++; $display("FAIL wr_no_valid: valid %b rdata %h want 0 5a", v7, rd7); end
    n_assert++; if (bif7.addr !== 16'hFF40) begin n_fail++; $display("FAIL wr_addr_hold: got %h want ff40", bif7.addr); end
  endtask

  task automatic test_back_to_back();
    wait_t0();
    drive_req(1'b0, 16'h1234, 8'h00);
    bif7.rdata = 8'hA5;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++; if (t7 !== 2'd0 || v7 !== 1'b1 || rd7 !== 8'hA5) begin n_fail++; $display("FAIL b2b_first: t %0d valid %b rdata %h want 0 1 a5", t7, v7, rd7); end
    drive_req(1'b0, 16'h5678, 8'h00);
    bif7.rdata = 8'h3C;
    @(negedge clk);
    en = 1'b0;
    n_assert++; if (t7 !== 2'd1 || bif7.rd !== 1'b1 || bif7.addr !== 16'h5678) begin n_fail++; $display("FAIL b2b_accept: t %0d rd %b addr %h want 1 1 5678", t7, bif7.rd, bif7.addr); end
    n_assert++; if (v7 !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_pulse: got %b want 0", v7); end
    repeat (3) @(negedge clk);
    n_assert++; if (v7 !== 1'b1 || rd7 !== 8'h3C) begin n_fail++; $display("FAIL b2b_second: valid %b rdata %h want 1 3c", v7, rd7); end
  endtask

  task automatic test_stall();
    bif7.ready = 1'b0;
    bif2.ready = 1'b1;
    do_reset();
    drive_req(1'b0, 16'hABCD, 8'h00);
    bif7.rdata = 8'h77;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_assert++; if (t7 !== 2'd3 || bif7.rd !== 1'b1) begin n_fail++; $display("FAIL stall_t3: t %0d rd %b want 3 1", t7, bif7.rd); end
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      n_assert++; if (t7 !== 2'd3 || bif7.rd !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: t %0d rd %b want 3 1", s, t7, bif7.rd); end
      n_assert++; if (to7 !== 1'b0 || v7 !== 1'b0) begin n_fail++; $display("FAIL stall_pulses[%0d]: timeout %b valid %b want 0 0", s, to7, v7); end
    end
    bif7.ready = 1'b1;
    @(negedge clk);
    n_assert++; if (t7 !== 2'd0 || bif7.rd !== 1'b0) begin n_fail++; $display("FAIL stall_done: t %0d rd %b want 0 0", t7, bif7.rd); end
    n_assert++; if (v7 !== 1'b1 || rd7 !== 8'h77 || to7 !== 1'b0) begin n_fail++; $display("FAIL stall_data: valid %b rdata %h timeout %b want 1 77 0", v7, rd7, to7); end
    @(negedge clk);
    n_assert++; if (t7 !== 2'd1) begin n_fail++; $display("FAIL stall_resume: t %0d want 1", t7); end
  endtask

  task automatic test_timeout();
    bif7.ready = 1'b0;
    bif2.ready = 1'b0;
    bif2.rdata = 8'h12;
    do_reset();
    drive_req(1'b0, 16'h0042, 8'h00);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_assert++; if (t2 !== 2'd3 || bif2.rd !== 1'b1 || to2 !== 1'b0) begin n_fail++; $display("FAIL to_t3: t %0d rd %b timeout %b want 3 1 0", t2, bif2.rd, to2); end
    for (int s = 1; s <= 2; s++) begin
      @(negedge clk);
      n_assert++; if (t2 !== 2'd3 || to2 !== 1'b0 || v2 !== 1'b0) begin n_fail++; $display("FAIL to_stall[%0d]: t %0d timeout %b valid %b want 3 0 0", s, t2, to2, v2); end
    end
    @(negedge clk);
    n_assert++; if (t2 !== 2'd0 || bif2.rd !== 1'b0) begin n_fail++; $display("FAIL to_abort: t %0d rd %b want 0 0", t2, bif2.rd); end
    n_assert++; if (to2 !== 1'b1 || v2 !== 1'b1 || rd2 !== 8'hFF) begin n_fail++; $display("FAIL to_pulse: timeout %b valid %b rdata %h want 1 1 ff", to2, v2, rd2); end
    n_assert++; if (t7 !== 2'd3 || to7 !== 1'b0) begin n_fail++; $display("FAIL to_wait7_still_stalled: t %0d timeout %b want 3 0", t7, to7); end
    @(negedge clk);
    n_assert++; if (to2 !== 1'b0 || v2 !== 1'b0 || t2 !== 2'd1 || rd2 !== 8'hFF) begin n_fail++; $display("FAIL to_after: timeout %b valid %b t %0d rdata %h want 0 0 1 ff", to2, v2, t2, rd2); end
  endtask

  task automatic test_reset_mid();
    bif7.ready = 1'b1;
    bif2.ready = 1'b1;
    do_reset();
    drive_req(1'b0, 16'h1111, 8'h00);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_assert++; if (t7 !== 2'd2 || bif7.rd !== 1'b1) begin n_fail++; $display("FAIL mid_before: t %0d rd %b want 2 1", t7, bif7.rd); end
    #2 reset_n = 1'b0;
    #1;
    n_assert++; if (bif7.rd !== 1'b0 || t7 !== 2'd0 || bif7.addr !== 16'h0) begin n_fail++; $display("FAIL mid_async: rd %b t %0d addr %h want 0 0 0000", bif7.rd, t7, bif7.addr); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_assert++; if (t7 !== 2'd0) begin n_fail++; $display("FAIL mid_release: t %0d want 0", t7); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_assert++; if (v7 !== 1'b0 || bif7.rd !== 1'b0) begin n_fail++; $display("FAIL mid_no_valid[%0d]: valid %b rd %b want 0 0", i, v7, bif7.rd); end
    end
  endtask

  initial begin
    bif7.ready = 1'b1;
    bif7.rdata = 8'h00;
    bif2.ready = 1'b1;
    bif2.rdata = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded limit, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule
